muldiv32: RTL and testbench
===========================

MULDIV32 -- requirements
Module: muldiv32

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse: begin operation `op` on `Read_data_1` and `Read_data_2`.
REQ-005 op  input  2  operation select, equal to Function_opcode[1:0]: 00 mult, 01 multu, 10 div, 11 divu.
REQ-006 Read_data_1  input  32  operand A (rs): multiplicand or dividend.
REQ-007 Read_data_2  input  32  operand B (rt): multiplier or divisor.
REQ-008 Mthi  input  1  write `Wdata` to HI.
REQ-009 Mtlo  input  1  write `Wdata` to LO.
REQ-010 Wdata  input  32  data for Mthi and Mtlo.
REQ-011 busy  output  1  high while an operation is in progress.
REQ-012 done  output  1  one-cycle pulse when HI and LO hold a new result.
REQ-013 Hi  output  32  HI register, read by mfhi.
REQ-014 Lo  output  32  LO register, read by mflo.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and FIX; busy SHALL be 1 in RUN and FIX, and 0 in IDLE.
REQ-016 In IDLE with start=1, the block SHALL latch op and both operands, clear the iteration counter, and move to RUN at that edge (edge E0).
REQ-017 For signed ops, the block SHALL store operand magnitudes, the result sign (A[31]^B[31]) and the remainder sign (A[31]).
REQ-018 RUN SHALL perform exactly 32 iterations, one per edge E1..E32: radix-2 shift-add for multiply, restoring shift-subtract for divide; at E32 the FSM SHALL move to FIX.
REQ-019 At E33 (FIX), the block SHALL apply sign correction, write Hi/Lo, go to IDLE, and assert done for the following cycle only.
REQ-020 Total latency SHALL be fixed: done=1 and the new Hi/Lo are visible in the cycle after E33, independent of operand values.
REQ-021 mult/multu SHALL produce the 64-bit product {Hi,Lo}, two's complement for mult.
REQ-022 div/divu SHALL produce Lo=quotient and Hi=remainder, truncating toward zero; the remainder takes the sign of the dividend.
REQ-023 Divide by zero (any divide op) SHALL still take the full latency and give Lo=32'hFFFF_FFFF and Hi=A.
REQ-024 Signed 32'h8000_0000 / 32'hFFFF_FFFF SHALL give Lo=32'h8000_0000 and Hi=0.
REQ-025 start while busy=1 SHALL be ignored, with no queueing and no change to the latched operands.
REQ-026 Mthi/Mtlo while busy=1 SHALL be ignored.
REQ-027 In IDLE, Mthi/Mtlo without start SHALL write Hi/Lo at the next edge; if Mthi and Mtlo are both asserted, both registers SHALL be written.
REQ-028 In IDLE, if start and Mthi/Mtlo are asserted in the same cycle, start SHALL win and the Mthi/Mtlo write SHALL be dropped.
REQ-029 Hi/Lo SHALL keep their previous values throughout RUN and SHALL change only at E33 or on an accepted Mthi/Mtlo write.
REQ-030 Lo SHALL depend only on its low-bits path and SHALL not depend on Hi.

Reset
REQ-031 On reset=1 at an edge, the block SHALL set state=IDLE, Hi=0, Lo=0, busy=0, done=0, clear the counter and drop any operation in progress.
REQ-032 reset SHALL take priority over start, Mthi and Mtlo in the same cycle.
REQ-033 Reset mid-operation SHALL produce no done pulse and no Hi/Lo update afterward.

Verification
REQ-034 mult A=32'hFFFF_FFFD (-3), B=7 -> Hi=32'hFFFF_FFFF, Lo=32'hFFFF_FFEB, done exactly 33 cycles after the start edge, busy high for 33 cycles.
REQ-035 multu A=B=32'hFFFF_FFFF -> Hi=32'hFFFF_FFFE, Lo=32'h0000_0001.
REQ-036 div A=-7, B=2 -> Lo=32'hFFFF_FFFD, Hi=32'hFFFF_FFFF; then divu A=100, B=0 -> Lo=32'hFFFF_FFFF, Hi=32'h0000_0064.
REQ-037 Start mult 5*6, pulse start with divu 9/3 at cycle 5 -> Lo=30 and Hi=0, only one done pulse.
REQ-038 Start any op, assert reset at cycle 10 -> next cycle busy=0, Hi=Lo=0, and no done in the following 40 cycles.
REQ-039 In IDLE, Mtlo with Wdata=32'h1234 -> Lo=32'h1234, Hi unchanged.
REQ-040 In IDLE, Mthi and start asserted together -> the Mthi write is dropped and the operation result is written at E33.

Source files
------------

// File: rtl/muldiv32_if.sv
// Handshake and HI/LO bus between the pipeline and the iterative multiply/divide unit.
interface muldiv32_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] Read_data_1;
  logic [31:0] Read_data_2;
  logic        Mthi;
  logic        Mtlo;
  logic [31:0] Wdata;
  logic        busy;
  logic        done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  modport master (
    output start, op, Read_data_1, Read_data_2, Mthi, Mtlo, Wdata,
    input  busy, done, Hi, Lo
  );

  modport slave (
    input  start, op, Read_data_1, Read_data_2, Mthi, Mtlo, Wdata,
    output busy, done, Hi, Lo
  );
endinterface

// File: rtl/muldiv32.sv
// Iterative 32-bit mult/multu/div/divu unit with HI/LO registers.
// Fixed latency: 32 radix-2 iterations plus one sign-fix cycle.
module muldiv32 (
  input  logic  clock,
  input  logic  reset,
  muldiv32_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t      state, state_nxt;
  logic [4:0]  cnt;
  logic        is_div, res_neg, rem_neg, div0;
  logic [31:0] opnd, work_hi, work_lo;
  logic [31:0] hi_q, lo_q;
  logic        done_q;

  logic        sgn_op;
  logic [31:0] a_abs, b_abs;
  logic [32:0] mul_sum, div_shift, div_trial;
  logic [31:0] step_hi, step_lo;
  logic [63:0] prod_abs, prod_fix;
  logic [31:0] quo_fix, rem_fix, fix_hi, fix_lo;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == 5'd31) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    sgn_op = ~bus.op[0];
    a_abs  = (sgn_op && bus.Read_data_1[31]) ? -bus.Read_data_1 : bus.Read_data_1;
    b_abs  = (sgn_op && bus.Read_data_2[31]) ? -bus.Read_data_2 : bus.Read_data_2;
  end

  // One iteration: shift-add for multiply (multiplier in work_lo), restoring
  // shift-subtract for divide (dividend shifts out of work_lo into work_hi).
  always_comb begin
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : '0);
    div_shift = {work_hi, work_lo[31]};
    div_trial = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (!div_trial[32]) begin
        step_hi = div_trial[31:0];
        step_lo = {work_lo[30:0], 1'b1};
      end else begin
        step_hi = div_shift[31:0];
        step_lo = {work_lo[30:0], 1'b0};
      end
    end else begin
      step_hi = mul_sum[32:1];
      step_lo = {mul_sum[0], work_lo[31:1]};
    end
  end

  // With a zero divisor the remainder path reproduces |A|, so only the quotient is forced.
  always_comb begin
    prod_abs = {work_hi, work_lo};
    prod_fix = res_neg ? -prod_abs : prod_abs;
    quo_fix  = div0 ? '1 : (res_neg ? -work_lo : work_lo);
    rem_fix  = rem_neg ? -work_hi : work_hi;
    fix_hi   = is_div ? rem_fix : prod_fix[63:32];
    fix_lo   = is_div ? quo_fix : prod_fix[31:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt     <= '0;
      is_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      div0    <= 1'b0;
      opnd    <= '0;
      work_hi <= '0;
      work_lo <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            cnt     <= '0;
            is_div  <= bus.op[1];
            res_neg <= sgn_op & (bus.Read_data_1[31] ^ bus.Read_data_2[31]);
            rem_neg <= sgn_op & bus.Read_data_1[31];
            div0    <= bus.op[1] & (bus.Read_data_2 == '0);
            opnd    <= bus.op[1] ? b_abs : a_abs;
            work_hi <= '0;
            work_lo <= bus.op[1] ? a_abs : b_abs;
          end else begin
            if (bus.Mthi) hi_q <= bus.Wdata;
            if (bus.Mtlo) lo_q <= bus.Wdata;
          end
        end
        RUN: begin
          work_hi <= step_hi;
          work_lo <= step_lo;
          cnt     <= cnt + 5'd1;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.busy = (state != IDLE);
    bus.done = done_q;
    bus.Hi   = hi_q;
    bus.Lo   = lo_q;
  end
endmodule

// File: tb/tb_muldiv32.sv
// Self-checking bench for muldiv32: vector table plus hand sequences, results via a scoreboard queue.
`timescale 1ns/1ps
module tb_muldiv32;
  logic clock = 1'b0;
  logic reset;

  muldiv32_if bus();
  muldiv32 dut (.clock(clock), .reset(reset), .bus(bus));

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t        vecs [0:9];
  logic [63:0] sb [$];
  int          n_pass = 0;
  int          n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa64, sb64;
    logic signed [31:0] sa, sbv, q, r;
    sa64 = {{32{a[31]}}, a};
    sb64 = {{32{b[31]}}, b};
    sa = a;
    sbv = b;
    case (op)
      2'd0: return sa64 * sb64;
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r, q};
      end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  task automatic clear_inputs();
    bus.start = 1'b0; bus.op = 2'd0; bus.Read_data_1 = '0; bus.Read_data_2 = '0;
    bus.Mthi = 1'b0; bus.Mtlo = 1'b0; bus.Wdata = '0;
  endtask

  task automatic pulse_start(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.start = 1'b1; bus.op = op; bus.Read_data_1 = a; bus.Read_data_2 = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output bit got);
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(posedge clock); #1;
      if (bus.done) got = 1'b1;
    end
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int busy_n, lat;
    bit got;
    logic [63:0] want;
    sb.push_back(exp);
    pulse_start(op, a, b);
    busy_n = bus.busy ? 1 : 0;
    lat = 0; got = 1'b0;
    while (lat < 100 && !got) begin
      @(posedge clock); #1;
      lat++;
      if (bus.done) got = 1'b1;
      else if (bus.busy) busy_n++;
    end
    check({name, " latency"}, lat, 33);
    check({name, " busy cycles"}, busy_n, 33);
    want = sb.pop_front();
    check({name, " result"}, {bus.Hi, bus.Lo}, want);
    @(posedge clock); #1;
    check({name, " done width"}, bus.done, 1'b0);
  endtask

  initial begin
    bit got;
    int pulses;
    logic [63:0] seen;
    logic [1:0] rop;
    logic [31:0] ra, rb;

    vecs[0] = '{2'd0, 32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'd2, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'd3, 32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF};
    vecs[4] = '{2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[5] = '{2'd2, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[6] = '{2'd2, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'd3, 32'hFFFF_FFFF, 32'd10,       32'h0000_0005, 32'h1999_9999};
    vecs[8] = '{2'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[9] = '{2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};

    clear_inputs();
    reset = 1'b1;
    bus.start = 1'b1; bus.Mthi = 1'b1; bus.Mtlo = 1'b1; bus.Wdata = 32'hCAFE_F00D;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    clear_inputs();
    @(posedge clock); #1;
    check("reset busy", bus.busy, 1'b0);
    check("reset done", bus.done, 1'b0);
    check("reset hilo", {bus.Hi, bus.Lo}, 64'd0);

    @(negedge clock); bus.Mthi = 1'b1; bus.Wdata = 32'h5555;
    @(negedge clock); bus.Mthi = 1'b0; bus.Mtlo = 1'b1; bus.Wdata = 32'h1234;
    @(negedge clock); bus.Mtlo = 1'b0;
    check("mtlo", {bus.Hi, bus.Lo}, {32'h5555, 32'h1234});
    bus.Mthi = 1'b1; bus.Mtlo = 1'b1; bus.Wdata = 32'hAAAA;
    @(negedge clock); clear_inputs();
    check("mthi+mtlo", {bus.Hi, bus.Lo}, {32'hAAAA, 32'hAAAA});

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});

    // start and Mthi while busy must be ignored
    sb.push_back(64'd30);
    pulse_start(2'd0, 32'd5, 32'd6);
    repeat (3) @(posedge clock);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'd3; bus.Read_data_1 = 32'd9; bus.Read_data_2 = 32'd3;
    bus.Mthi = 1'b1; bus.Wdata = 32'hDEAD;
    @(negedge clock); clear_inputs();
    pulses = 0; seen = '0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clock); #1;
      if (bus.done) begin pulses++; seen = {bus.Hi, bus.Lo}; end
    end
    check("busy-ignore pulses", pulses, 1);
    check("busy-ignore result", seen, sb.pop_front());
    check("busy-ignore idle", bus.busy, 1'b0);

    // Mthi together with start: write dropped
    @(negedge clock); bus.Mthi = 1'b1; bus.Mtlo = 1'b1; bus.Wdata = 32'hAAAA;
    @(negedge clock); clear_inputs();
    sb.push_back(64'd6);
    @(negedge clock);
    bus.start = 1'b1; bus.op = 2'd0; bus.Read_data_1 = 32'd2; bus.Read_data_2 = 32'd3;
    bus.Mthi = 1'b1; bus.Wdata = 32'hDEAD;
    @(posedge clock); #1; clear_inputs();
    repeat (3) @(posedge clock); #1;
    check("hold during run", {bus.Hi, bus.Lo}, {32'hAAAA, 32'hAAAA});
    wait_done(got);
    check("start-wins done", got, 1'b1);
    check("start-wins result", {bus.Hi, bus.Lo}, sb.pop_front());

    for (int i = 0; i < 6; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = $urandom();
      rb = (i == 2) ? 32'd0 : $urandom();
      if (i == 3) rb = 32'd1;
      run_op($sformatf("rand%0d", i), rop, ra, rb, model(rop, ra, rb));
    end

    // reset in the middle of an operation
    pulse_start(2'd1, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(posedge clock);
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1; reset = 1'b0;
    check("midreset busy", bus.busy, 1'b0);
    check("midreset hilo", {bus.Hi, bus.Lo}, 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock); #1;
      if (bus.done) pulses++;
    end
    check("midreset no done", pulses, 0);
    check("midreset hilo hold", {bus.Hi, bus.Lo}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
